// File: rtl/collision_detector.sv
// collision_detector
//
// Once per video frame, walks the object table and tests each occupied slot
// against the player box (axis-aligned, strict overlap: touching edges do not
// count). Emits a single-cycle o_Collision pulse for the lives counter,
// together with the lowest-numbered slot that hit.
//
// Optional feature, selected by the macro COLLISION_GRACE_EN:
//   defined   - after a reported hit, the next GRACE_FRAMES scans are
//               suppressed (no pulse, o_Hit_Index held); o_Grace is high while
//               the window is open.
//   undefined - no grace counter; every hitting scan reports; o_Grace = 0.
//
// Scan timeline (cycle 0 = the cycle in which i_Frame_Start is sampled in IDLE):
//   0                : latch player position, clear hit flag
//   1 .. NUM_OBJ     : SCAN, o_Obj_Index = 0 .. NUM_OBJ-1
//   NUM_OBJ+1        : DRAIN, compare the last slot
//   NUM_OBJ+2        : REPORT, decision registered, back to IDLE
//   NUM_OBJ+3        : o_Collision high (if reported)
//
// Ports (IW = $clog2(NUM_OBJ)):
//   i_Clk          in   1        system clock
//   i_Reset        in   1        synchronous reset, active-high
//   i_Frame_Start  in   1        1-cycle pulse, starts a scan (ignored while busy)
//   i_Player_X/Y   in   COORD_W  player top-left, sampled when a scan starts
//   o_Obj_Index    out  IW       object table read address (holds in IDLE)
//   i_Obj_X/Y      in   COORD_W  object top-left, valid the cycle after o_Obj_Index
//   i_Obj_Valid    in   1        slot occupied, same timing as i_Obj_X/Y
//   o_Collision    out  1        1-cycle hit pulse
//   o_Hit_Index    out  IW       lowest hit slot of the last reported collision
//   o_Busy         out  1        scan in progress
//   o_Grace        out  1        grace window active

module collision_detector #(
    parameter int NUM_OBJ      = 8,
    parameter int COORD_W      = 10,
    parameter int PLAYER_W     = 16,
    parameter int PLAYER_H     = 16,
    parameter int OBJ_W        = 16,
    parameter int OBJ_H        = 16,
    parameter int GRACE_FRAMES = 60,
    localparam int IW          = $clog2(NUM_OBJ)
) (
    input  logic               i_Clk,
    input  logic               i_Reset,
    input  logic               i_Frame_Start,
    input  logic [COORD_W-1:0] i_Player_X,
    input  logic [COORD_W-1:0] i_Player_Y,
    output logic [IW-1:0]      o_Obj_Index,
    input  logic [COORD_W-1:0] i_Obj_X,
    input  logic [COORD_W-1:0] i_Obj_Y,
    input  logic               i_Obj_Valid,
    output logic               o_Collision,
    output logic [IW-1:0]      o_Hit_Index,
    output logic               o_Busy,
    output logic               o_Grace
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SCAN   = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_REPORT = 2'd3;

    // Sums are formed one bit wider than the coordinates so that a box near
    // the right/bottom edge of the coordinate space cannot wrap around.
    localparam int SW = COORD_W + 1;

    localparam logic [IW-1:0] LAST_SLOT = IW'(NUM_OBJ - 1);

    logic [1:0]         state;
    logic [COORD_W-1:0] player_x;
    logic [COORD_W-1:0] player_y;

    // Read-return tracking: rd_pending marks a cycle in which i_Obj_* carries
    // data for slot rd_slot (addressed one cycle earlier).
    logic               rd_pending;
    logic [IW-1:0]      rd_slot;

    logic               hit_found;
    logic [IW-1:0]      hit_slot;

    logic [SW-1:0]      px_e;
    logic [SW-1:0]      py_e;
    logic [SW-1:0]      ox_e;
    logic [SW-1:0]      oy_e;
    logic               overlap;

    assign px_e = {1'b0, player_x};
    assign py_e = {1'b0, player_y};
    assign ox_e = {1'b0, i_Obj_X};
    assign oy_e = {1'b0, i_Obj_Y};

    always_comb begin
        overlap = i_Obj_Valid
                & (px_e < ox_e + SW'(OBJ_W))
                & (ox_e < px_e + SW'(PLAYER_W))
                & (py_e < oy_e + SW'(OBJ_H))
                & (oy_e < py_e + SW'(PLAYER_H));
    end

    assign o_Busy = (state != ST_IDLE);

`ifdef COLLISION_GRACE_EN
    localparam int GW = (GRACE_FRAMES > 0) ? $clog2(GRACE_FRAMES + 1) : 1;

    logic [GW-1:0] grace_cnt;

    assign o_Grace = (grace_cnt != '0);
`else
    assign o_Grace = 1'b0;
`endif

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state       <= ST_IDLE;
            player_x    <= '0;
            player_y    <= '0;
            o_Obj_Index <= '0;
            rd_pending  <= 1'b0;
            rd_slot     <= '0;
            hit_found   <= 1'b0;
            hit_slot    <= '0;
            o_Collision <= 1'b0;
            o_Hit_Index <= '0;
`ifdef COLLISION_GRACE_EN
            grace_cnt   <= '0;
`endif
        end else begin
            o_Collision <= 1'b0;
            rd_pending  <= (state == ST_SCAN);
            rd_slot     <= o_Obj_Index;

            // First hit of the scan is kept; later hits never overwrite it.
            if (rd_pending && overlap && !hit_found) begin
                hit_found <= 1'b1;
                hit_slot  <= rd_slot;
            end

            case (state)
                ST_IDLE: begin
                    if (i_Frame_Start) begin
                        player_x    <= i_Player_X;
                        player_y    <= i_Player_Y;
                        hit_found   <= 1'b0;
                        o_Obj_Index <= '0;
                        state       <= ST_SCAN;
                    end
                end

                ST_SCAN: begin
                    if (o_Obj_Index == LAST_SLOT) begin
                        state <= ST_DRAIN;
                    end else begin
                        o_Obj_Index <= o_Obj_Index + 1'b1;
                    end
                end

                ST_DRAIN: begin
                    state <= ST_REPORT;
                end

                ST_REPORT: begin
                    state <= ST_IDLE;
`ifdef COLLISION_GRACE_EN
                    // An open window swallows this scan whether or not it hit.
                    if (grace_cnt != '0) begin
                        grace_cnt <= grace_cnt - 1'b1;
                    end else if (hit_found) begin
                        o_Collision <= 1'b1;
                        o_Hit_Index <= hit_slot;
                        grace_cnt   <= GW'(GRACE_FRAMES);
                    end
`else
                    if (hit_found) begin
                        o_Collision <= 1'b1;
                        o_Hit_Index <= hit_slot;
                    end
`endif
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_collision_detector.sv
// Testbench for collision_detector: table of scan vectors plus hand-written
// restart / mid-scan reset sequences. Expected per-scan results are queued when
// the scan is launched and compared when its observation window closes.

module tb_collision_detector;

    localparam int NUM_OBJ = 8;
    localparam int IW      = 3;
    localparam int CW      = 10;
    localparam int GRACE   = 2;
    localparam int WIN     = 24;
    localparam int NVEC    = 14;

`ifdef COLLISION_GRACE_EN
    localparam bit GRACE_EN = 1'b1;
`else
    localparam bit GRACE_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] player_x;
    logic [CW-1:0] player_y;
    logic [IW-1:0] obj_index;
    logic [CW-1:0] obj_x;
    logic [CW-1:0] obj_y;
    logic          obj_valid;
    logic          collision;
    logic [IW-1:0] hit_index;
    logic          busy;
    logic          grace;

    always #5 clk = ~clk;

    collision_detector #(
        .NUM_OBJ      (NUM_OBJ),
        .COORD_W      (CW),
        .PLAYER_W     (16),
        .PLAYER_H     (16),
        .OBJ_W        (16),
        .OBJ_H        (16),
        .GRACE_FRAMES (GRACE)
    ) dut (
        .i_Clk         (clk),
        .i_Reset       (rst),
        .i_Frame_Start (start),
        .i_Player_X    (player_x),
        .i_Player_Y    (player_y),
        .o_Obj_Index   (obj_index),
        .i_Obj_X       (obj_x),
        .i_Obj_Y       (obj_y),
        .i_Obj_Valid   (obj_valid),
        .o_Collision   (collision),
        .o_Hit_Index   (hit_index),
        .o_Busy        (busy),
        .o_Grace       (grace)
    );

    // Object table with a 1-cycle-latency read port.
    logic [CW-1:0] mem_x [NUM_OBJ];
    logic [CW-1:0] mem_y [NUM_OBJ];
    logic          mem_v [NUM_OBJ];

    always @(posedge clk) begin
        obj_x     <= mem_x[obj_index];
        obj_y     <= mem_y[obj_index];
        obj_valid <= mem_v[obj_index];
    end

    typedef struct {
        logic          rst;
        logic [CW-1:0] px;
        logic [CW-1:0] py;
        logic [CW-1:0] ox;
        logic [CW-1:0] oy;
        logic [7:0]    pos;    // slots placed at (ox,oy); others sit far away
        logic [7:0]    valid;
        logic          hit;    // raw geometric hit in this scan
        logic [IW-1:0] idx;    // lowest hitting slot
    } vec_t;

    typedef struct {
        logic [WIN-1:0] coll;
        logic [WIN-1:0] busy;
        logic [IW-1:0]  idx;
        logic           grace;
    } exp_t;

    vec_t   vecs [NVEC];
    exp_t   sb [$];
    int     checks = 0;
    int     errors = 0;
    int     m_grace;
    logic [IW-1:0] m_idx;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst     = 1'b0;
        m_grace = 0;
        m_idx   = '0;
    endtask

    task automatic load_mem(input vec_t v);
        for (int i = 0; i < NUM_OBJ; i++) begin
            mem_x[i] = v.pos[i] ? v.ox : CW'(500);
            mem_y[i] = v.pos[i] ? v.oy : CW'(20);
            mem_v[i] = v.valid[i];
        end
    endtask

    // restart: cycle in which i_Frame_Start is re-pulsed (0 = none)
    // rst_cyc: cycle in which i_Reset is asserted (0 = none)
    task automatic run_scan(input vec_t v, input int restart, input int rst_cyc, input string name);
        exp_t           e;
        exp_t           got;
        logic           pulse;
        logic [WIN-1:0] coll_s;
        logic [WIN-1:0] busy_s;
        logic [23:0]    idx_s;
        logic [23:0]    idx_e;

        load_mem(v);
        player_x = v.px;
        player_y = v.py;

        if (rst_cyc != 0) begin
            e.coll  = '0;
            e.busy  = (WIN'(1) << rst_cyc) - WIN'(1);
            m_grace = 0;
            m_idx   = '0;
        end else begin
            if (GRACE_EN) begin
                pulse = v.hit && (m_grace == 0);
                if (m_grace > 0)
                    m_grace--;
                else if (v.hit)
                    m_grace = GRACE;
            end else begin
                pulse = v.hit;
            end
            if (pulse)
                m_idx = v.idx;
            e.coll = pulse ? (WIN'(1) << 10) : '0;
            e.busy = WIN'(24'h0003FF);
        end
        e.idx   = m_idx;
        e.grace = (m_grace != 0);
        sb.push_back(e);

        coll_s = '0;
        busy_s = '0;
        idx_s  = '0;
        for (int i = 0; i < NUM_OBJ; i++)
            idx_e[i*3 +: 3] = IW'(i);

        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= WIN; c++) begin
            @(negedge clk);
            coll_s[c-1] = collision;
            busy_s[c-1] = busy;
            if (c <= NUM_OBJ)
                idx_s[(c-1)*3 +: 3] = obj_index;
            if (rst_cyc != 0 && c == rst_cyc + 1)
                check({name, ".after_reset"},
                      64'({collision, busy, grace, hit_index, obj_index}), 64'd0);
            if (c == 1)
                start = 1'b0;
            if (restart != 0 && c == restart) begin
                start    = 1'b1;
                player_x = CW'(600);   // must not disturb the latched position
            end
            if (restart != 0 && c == restart + 1)
                start = 1'b0;
            if (rst_cyc != 0 && c == rst_cyc)
                rst = 1'b1;
            if (rst_cyc != 0 && c == rst_cyc + 1)
                rst = 1'b0;
        end

        got = sb.pop_front();
        check({name, ".coll"},  64'(coll_s), 64'(got.coll));
        check({name, ".busy"},  64'(busy_s), 64'(got.busy));
        check({name, ".hitidx"}, 64'(hit_index), 64'(got.idx));
        check({name, ".grace"}, 64'(grace), 64'(got.grace));
        if (rst_cyc == 0)
            check({name, ".addr"}, 64'(idx_s), 64'(idx_e));
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        player_x = '0;
        player_y = '0;
        for (int i = 0; i < NUM_OBJ; i++) begin
            mem_x[i] = '0;
            mem_y[i] = '0;
            mem_v[i] = 1'b0;
        end

        //          rst   px       py       ox        oy        pos    valid  hit   idx
        vecs[0]  = '{1'b1, 10'd100, 10'd100, 10'd110,  10'd108,  8'h08, 8'h08, 1'b1, 3'd3}; // T1
        vecs[1]  = '{1'b1, 10'd100, 10'd100, 10'd116,  10'd100,  8'h01, 8'h01, 1'b0, 3'd0}; // x touch
        vecs[2]  = '{1'b0, 10'd100, 10'd100, 10'd115,  10'd100,  8'h01, 8'h01, 1'b1, 3'd0}; // x overlap 1px
        vecs[3]  = '{1'b1, 10'd100, 10'd100, 10'd105,  10'd95,   8'hA4, 8'hFF, 1'b1, 3'd2}; // multi-hit
        vecs[4]  = '{1'b1, 10'd200, 10'd300, 10'd190,  10'd310,  8'h02, 8'h02, 1'b1, 3'd1}; // grace frame 1
        vecs[5]  = '{1'b0, 10'd200, 10'd300, 10'd190,  10'd310,  8'h02, 8'h02, 1'b1, 3'd1}; // frame 2
        vecs[6]  = '{1'b0, 10'd200, 10'd300, 10'd190,  10'd310,  8'h02, 8'h02, 1'b1, 3'd1}; // frame 3
        vecs[7]  = '{1'b0, 10'd200, 10'd300, 10'd190,  10'd310,  8'h02, 8'h02, 1'b1, 3'd1}; // frame 4
        vecs[8]  = '{1'b1, 10'd1000, 10'd1000, 10'd1015, 10'd1015, 8'h10, 8'h10, 1'b1, 3'd4}; // no wrap
        vecs[9]  = '{1'b0, 10'd1000, 10'd1000, 10'd1015, 10'd1015, 8'h10, 8'h00, 1'b0, 3'd0}; // invalid slot
        vecs[10] = '{1'b1, 10'd100, 10'd100, 10'd100,  10'd84,   8'h40, 8'h40, 1'b0, 3'd0}; // y touch
        vecs[11] = '{1'b0, 10'd100, 10'd100, 10'd100,  10'd85,   8'h40, 8'h40, 1'b1, 3'd6}; // y overlap 1px
        vecs[12] = '{1'b1, 10'd100, 10'd100, 10'd600,  10'd600,  8'h00, 8'hFF, 1'b0, 3'd0}; // all valid, far
        vecs[13] = '{1'b1, 10'd0,   10'd0,   10'd0,    10'd0,    8'h80, 8'hFF, 1'b1, 3'd7}; // last slot only

        do_reset();
        check("reset_state", 64'({collision, busy, grace, hit_index, obj_index}), 64'd0);

        for (int i = 0; i < NVEC; i++) begin
            if (vecs[i].rst)
                do_reset();
            run_scan(vecs[i], 0, 0, $sformatf("v%0d", i));
        end

        // Start re-pulsed mid-scan must be dropped, not queued.
        do_reset();
        run_scan(vecs[0], 5, 0, "t5_restart");

        // Reset in cycle 6 of a hitting scan aborts it silently.
        do_reset();
        run_scan(vecs[0], 0, 6, "t5_reset");

        // The next scan behaves exactly like a fresh one.
        run_scan(vecs[0], 0, 0, "t5_after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
